// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, EX operand
// forwarding and stall sequencing for multi-cycle EX operations with timeout.
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 34
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs1_addr_d,
  input  logic [4:0]  rs2_addr_d,
  input  logic        rs1_used_d,
  input  logic        rs2_used_d,
  input  logic [4:0]  rs1_addr_e,
  input  logic [4:0]  rs2_addr_e,
  input  logic [4:0]  reg_dest_addr_e,
  input  logic        wb_sel_e,
  input  logic [2:0]  result_mux_sel_e,
  input  logic [4:0]  reg_dest_addr_m,
  input  logic        wb_sel_m,
  input  logic [4:0]  reg_dest_addr_w,
  input  logic        wb_sel_w,
  input  logic        branch_taken_e,
  input  logic        mc_start_e,
  input  logic        mc_done_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        flush_d,
  output logic        flush_ex,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mc_timeout_o,
  output logic [31:0] stall_cnt_o
);

  localparam int CNT_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [2:0] RES_LOAD = 3'b001;

  typedef enum logic [1:0] {RUN, MC_BUSY, MC_DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] mc_cnt;
  logic             load_use;

  // MEM result is newer than WB, so it wins when both match; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       wb_m, input logic [4:0] rd_m,
                                         input logic       wb_w, input logic [4:0] rd_w);
    if (wb_m && (rd_m != 5'd0) && (rd_m == src))
      return 2'b01;
    else if (wb_w && (rd_w != 5'd0) && (rd_w == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  always_comb begin
    load_use = wb_sel_e && (result_mux_sel_e == RES_LOAD) && (reg_dest_addr_e != 5'd0) &&
               ((rs1_used_d && (rs1_addr_d == reg_dest_addr_e)) ||
                (rs2_used_d && (rs2_addr_d == reg_dest_addr_e)));
  end

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_ex  = 1'b0;
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (!rst_i) begin
      fwd_a_sel = fwd_sel(rs1_addr_e, wb_sel_m, reg_dest_addr_m, wb_sel_w, reg_dest_addr_w);
      fwd_b_sel = fwd_sel(rs2_addr_e, wb_sel_m, reg_dest_addr_m, wb_sel_w, reg_dest_addr_w);
      unique case (state)
        RUN: begin
          // A taken branch squashes the dependent ID instruction, so no interlock is needed.
          if (branch_taken_e) begin
            flush_d  = 1'b1;
            flush_ex = 1'b1;
          end else if (!mc_start_e && load_use) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            flush_ex = 1'b1;
          end
        end
        MC_BUSY: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
        end
        MC_DRAIN: flush_ex = load_use;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= RUN;
      mc_cnt       <= '0;
      mc_timeout_o <= 1'b0;
      stall_cnt_o  <= '0;
    end else begin
      if (stall_f && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      unique case (state)
        RUN: begin
          // A start coinciding with its own done is treated as still outstanding.
          if (!branch_taken_e && mc_start_e)
            state <= MC_BUSY;
        end
        MC_BUSY: begin
          mc_cnt <= mc_cnt + 1'b1;
          if (mc_done_e) begin
            state <= MC_DRAIN;
          end else if (mc_cnt == CNT_W'(MC_TIMEOUT - 1)) begin
            mc_timeout_o <= 1'b1;
            state        <= MC_DRAIN;
          end
        end
        MC_DRAIN: begin
          mc_cnt <= '0;
          state  <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int TO = 34;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e;
  logic        rs1_used_d, rs2_used_d;
  logic [4:0]  reg_dest_addr_e, reg_dest_addr_m, reg_dest_addr_w;
  logic        wb_sel_e, wb_sel_m, wb_sel_w;
  logic [2:0]  result_mux_sel_e;
  logic        branch_taken_e, mc_start_e, mc_done_e;
  logic        stall_f, stall_d, stall_e, flush_d, flush_ex, mc_timeout_o;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  hazard_ctrl #(.MC_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_addr_d(rs1_addr_d), .rs2_addr_d(rs2_addr_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .rs1_addr_e(rs1_addr_e), .rs2_addr_e(rs2_addr_e),
    .reg_dest_addr_e(reg_dest_addr_e), .wb_sel_e(wb_sel_e), .result_mux_sel_e(result_mux_sel_e),
    .reg_dest_addr_m(reg_dest_addr_m), .wb_sel_m(wb_sel_m),
    .reg_dest_addr_w(reg_dest_addr_w), .wb_sel_w(wb_sel_w),
    .branch_taken_e(branch_taken_e), .mc_start_e(mc_start_e), .mc_done_e(mc_done_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_ex(flush_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mc_timeout_o(mc_timeout_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural model: busy_left counts how many busy cycles have elapsed (-1 = not busy).
  int     m_busy_n = -1;
  bit     m_drain  = 1'b0;
  bit     m_to     = 1'b0;
  longint m_cnt    = 0;

  // {stall_f, stall_d, stall_e, flush_d, flush_ex, fwd_a, fwd_b, mc_timeout}
  function automatic logic [9:0] obs_vec();
    return {stall_f, stall_d, stall_e, flush_d, flush_ex, fwd_a_sel, fwd_b_sel, mc_timeout_o};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (wb_sel_m && reg_dest_addr_m != 0 && reg_dest_addr_m == src) return 2'b01;
    if (wb_sel_w && reg_dest_addr_w != 0 && reg_dest_addr_w == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit m_load_use();
    return wb_sel_e && result_mux_sel_e == 3'b001 && reg_dest_addr_e != 0 &&
           ((rs1_used_d && rs1_addr_d == reg_dest_addr_e) ||
            (rs2_used_d && rs2_addr_d == reg_dest_addr_e));
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [4:0] ctl;
    if (rst_i) return {9'd0, m_to};
    if (m_busy_n >= 0)  ctl = 5'b11100;
    else if (m_drain)   ctl = {4'b0000, m_load_use()};
    else if (branch_taken_e) ctl = 5'b00011;
    else if (mc_start_e)     ctl = 5'b00000;
    else if (m_load_use())   ctl = 5'b11001;
    else                     ctl = 5'b00000;
    return {ctl, m_fwd(rs1_addr_e), m_fwd(rs2_addr_e), m_to};
  endfunction

  // Advance one clock; model next-state is computed from the pre-edge inputs.
  task automatic step();
    int     n_busy  = m_busy_n;
    bit     n_drain = 1'b0;
    bit     n_to    = m_to;
    longint n_cnt   = m_cnt;
    logic [9:0] e = exp_vec();
    if (rst_i) begin
      n_busy = -1; n_to = 0; n_cnt = 0;
    end else begin
      if (e[9] && n_cnt < 64'hFFFF_FFFF) n_cnt++;
      if (m_busy_n >= 0) begin
        if (mc_done_e) begin n_busy = -1; n_drain = 1; end
        else if (m_busy_n + 1 == TO) begin n_busy = -1; n_drain = 1; n_to = 1; end
        else n_busy = m_busy_n + 1;
      end else if (!m_drain && !branch_taken_e && mc_start_e) begin
        n_busy = 0;
      end
    end
    @(posedge clk_i);
    #1;
    m_busy_n = n_busy; m_drain = n_drain; m_to = n_to; m_cnt = n_cnt;
  endtask

  task automatic clear_inputs();
    rs1_addr_d = 0; rs2_addr_d = 0; rs1_used_d = 0; rs2_used_d = 0;
    rs1_addr_e = 0; rs2_addr_e = 0;
    reg_dest_addr_e = 0; wb_sel_e = 0; result_mux_sel_e = 0;
    reg_dest_addr_m = 0; wb_sel_m = 0; reg_dest_addr_w = 0; wb_sel_w = 0;
    branch_taken_e = 0; mc_start_e = 0; mc_done_e = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    wb_sel_e = 1; result_mux_sel_e = 3'b001; reg_dest_addr_e = rd;
    rs1_addr_d = rd; rs1_used_d = 1;
  endtask

  task automatic do_reset();
    rst_i = 1; clear_inputs(); step(); rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; clear_inputs(); step();
    set_load_use(5'd7); branch_taken_e = 1; mc_start_e = 1;
    reg_dest_addr_m = 3; wb_sel_m = 1; rs1_addr_e = 3; rs2_addr_e = 3;
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0 || stall_cnt_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b cnt %0d, want %b cnt 0", obs_vec(), stall_cnt_o, 10'd0);
    end
    step();
    rst_i = 0; clear_inputs();
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0 || stall_cnt_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_idle: got %b cnt %0d, want %b cnt 0", obs_vec(), stall_cnt_o, 10'd0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use(5'd5);
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'b11001_00_00_0 || stall_cnt_o !== 32'd0) begin
      miscompares++;
      $display("FAIL load_use_stall: got %b cnt %0d, want %b cnt 0", obs_vec(), stall_cnt_o, 10'b1100100000);
    end
    step(); clear_inputs();
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0 || stall_cnt_o !== 32'd1) begin
      miscompares++;
      $display("FAIL load_use_after: got %b cnt %0d, want %b cnt 1", obs_vec(), stall_cnt_o, 10'd0);
    end
    // rs2 path, and a non-load producer must not interlock
    clear_inputs(); wb_sel_e = 1; result_mux_sel_e = 3'b001; reg_dest_addr_e = 9;
    rs2_addr_d = 9; rs2_used_d = 1;
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'b11001_00_00_0) begin
      miscompares++;
      $display("FAIL load_use_rs2: got %b, want %b", obs_vec(), 10'b1100100000);
    end
    result_mux_sel_e = 3'b000;
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0) begin
      miscompares++;
      $display("FAIL non_load_no_stall: got %b, want %b", obs_vec(), 10'd0);
    end
    clear_inputs(); set_load_use(5'd0);
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0) begin
      miscompares++;
      $display("FAIL load_use_x0: got %b, want %b", obs_vec(), 10'd0);
    end
    clear_inputs(); step();
  endtask

  task automatic test_forwarding();
    do_reset();
    reg_dest_addr_m = 3; wb_sel_m = 1; reg_dest_addr_w = 3; wb_sel_w = 1;
    rs1_addr_e = 3; rs2_addr_e = 3;
    @(negedge clk_i);
    vectors++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
      miscompares++;
      $display("FAIL fwd_mem_priority: got a=%b b=%b, want a=01 b=01", fwd_a_sel, fwd_b_sel);
    end
    reg_dest_addr_m = 0;
    @(negedge clk_i);
    vectors++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
      miscompares++;
      $display("FAIL fwd_wb: got a=%b b=%b, want a=10 b=10", fwd_a_sel, fwd_b_sel);
    end
    reg_dest_addr_m = 4; wb_sel_m = 1; rs2_addr_e = 4;
    @(negedge clk_i);
    vectors++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b01) begin
      miscompares++;
      $display("FAIL fwd_split: got a=%b b=%b, want a=10 b=01", fwd_a_sel, fwd_b_sel);
    end
    clear_inputs(); wb_sel_m = 1; wb_sel_w = 1;
    @(negedge clk_i);
    vectors++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      miscompares++;
      $display("FAIL fwd_x0: got a=%b b=%b, want a=00 b=00", fwd_a_sel, fwd_b_sel);
    end
    wb_sel_m = 0; wb_sel_w = 0; reg_dest_addr_m = 6; reg_dest_addr_w = 6; rs1_addr_e = 6;
    @(negedge clk_i);
    vectors++;
    if (fwd_a_sel !== 2'b00) begin
      miscompares++;
      $display("FAIL fwd_no_write: got a=%b, want a=00", fwd_a_sel);
    end
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_load_use(5'd5); branch_taken_e = 1;
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'b00011_00_00_0) begin
      miscompares++;
      $display("FAIL branch_over_load_use: got %b, want %b", obs_vec(), 10'b0001100000);
    end
    clear_inputs(); branch_taken_e = 1; mc_start_e = 1;
    step(); clear_inputs();
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0 || stall_cnt_o !== 32'd0) begin
      miscompares++;
      $display("FAIL branch_over_start: got %b cnt %0d, want %b cnt 0", obs_vec(), stall_cnt_o, 10'd0);
    end
  endtask

  task automatic test_mc_op();
    do_reset();
    set_load_use(5'd5); mc_start_e = 1;
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0) begin
      miscompares++;
      $display("FAIL mc_start_cycle: got %b, want %b", obs_vec(), 10'd0);
    end
    step(); clear_inputs();
    for (int i = 1; i <= 3; i++) begin
      branch_taken_e = (i == 2);
      mc_done_e = (i == 3);
      @(negedge clk_i);
      vectors++;
      if (obs_vec() !== 10'b11100_00_00_0) begin
        miscompares++;
        $display("FAIL mc_busy_%0d: got %b, want %b", i, obs_vec(), 10'b1110000000);
      end
      step();
    end
    clear_inputs(); set_load_use(5'd8);
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'b00001_00_00_0 || stall_cnt_o !== 32'd3) begin
      miscompares++;
      $display("FAIL mc_drain: got %b cnt %0d, want %b cnt 3", obs_vec(), stall_cnt_o, 10'b0000100000);
    end
    step(); clear_inputs();
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0 || stall_cnt_o !== 32'd3) begin
      miscompares++;
      $display("FAIL mc_back_to_run: got %b cnt %0d, want %b cnt 3", obs_vec(), stall_cnt_o, 10'd0);
    end
  endtask

  task automatic test_mc_done_same_cycle();
    do_reset();
    mc_start_e = 1; mc_done_e = 1;
    step(); mc_start_e = 0;
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'b11100_00_00_0) begin
      miscompares++;
      $display("FAIL done_with_start_ignored: got %b, want %b", obs_vec(), 10'b1110000000);
    end
    step(); clear_inputs();
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0 || stall_cnt_o !== 32'd1) begin
      miscompares++;
      $display("FAIL done_first_busy: got %b cnt %0d, want %b cnt 1", obs_vec(), stall_cnt_o, 10'd0);
    end
    step();
  endtask

  task automatic test_timeout();
    int bad = 0;
    do_reset();
    mc_start_e = 1; step(); clear_inputs();
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk_i);
      if (obs_vec() !== 10'b11100_00_00_0) bad++;
      step();
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL timeout_busy_span: %0d of %0d busy cycles wrong, want 0", bad, TO);
    end
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'b00000_00_00_1 || stall_cnt_o !== 32'd34) begin
      miscompares++;
      $display("FAIL timeout_flag: got %b cnt %0d, want %b cnt 34", obs_vec(), stall_cnt_o, 10'b0000000001);
    end
    step(); step(); set_load_use(5'd2);
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'b11001_00_00_1) begin
      miscompares++;
      $display("FAIL timeout_sticky: got %b, want %b", obs_vec(), 10'b1100100001);
    end
    clear_inputs(); step();
  endtask

  task automatic test_reset_in_busy();
    do_reset();
    mc_start_e = 1; step(); clear_inputs(); step();
    rst_i = 1;
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_busy_gated: got %b, want %b", obs_vec(), 10'd0);
    end
    step(); rst_i = 0;
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'd0 || stall_cnt_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_busy_after: got %b cnt %0d, want %b cnt 0", obs_vec(), stall_cnt_o, 10'd0);
    end
    // A load-use stall here (not a drain-style flush alone) shows the op was abandoned straight to RUN.
    set_load_use(5'd11);
    @(negedge clk_i);
    vectors++;
    if (obs_vec() !== 10'b11001_00_00_0) begin
      miscompares++;
      $display("FAIL reset_busy_no_drain: got %b, want %b", obs_vec(), 10'b1100100000);
    end
    clear_inputs(); step();
  endtask

  task automatic test_random();
    logic [9:0] e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_i            = ($urandom_range(0, 79) == 0);
      rs1_addr_d       = 5'($urandom_range(0, 3));
      rs2_addr_d       = 5'($urandom_range(0, 3));
      rs1_used_d       = 1'($urandom);
      rs2_used_d       = 1'($urandom);
      rs1_addr_e       = 5'($urandom_range(0, 3));
      rs2_addr_e       = 5'($urandom_range(0, 3));
      reg_dest_addr_e  = 5'($urandom_range(0, 3));
      wb_sel_e         = 1'($urandom);
      result_mux_sel_e = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom);
      reg_dest_addr_m  = 5'($urandom_range(0, 3));
      wb_sel_m         = 1'($urandom);
      reg_dest_addr_w  = 5'($urandom_range(0, 3));
      wb_sel_w         = 1'($urandom);
      branch_taken_e   = ($urandom_range(0, 5) == 0);
      mc_start_e       = ($urandom_range(0, 7) == 0);
      mc_done_e        = ($urandom_range(0, 9) == 0);
      @(negedge clk_i);
      e = exp_vec();
      vectors++;
      if (obs_vec() !== e || stall_cnt_o !== m_cnt[31:0]) begin
        miscompares++;
        $display("FAIL random_%0d: got %b cnt %0d, want %b cnt %0d", i, obs_vec(), stall_cnt_o, e, m_cnt);
      end
      step();
    end
    rst_i = 0; clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_priority();
    test_mc_op();
    test_mc_done_same_cycle();
    test_timeout();
    test_reset_in_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
